// File: rtl/dma_arbiter.sv
// dma_arbiter: shares one DMA controller among NDEV requesting devices
// Ports: clk, reset (async, active-high); dev_* per-device request, descriptor,
// handshake and data (packed, device i at slice i); dma_* the single DMA side;
// grant is the one-hot owner (0 when idle), busy is high outside IDLE.
// Define DMA_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module dma_arbiter #(
  parameter int NDEV = 4,
  parameter int DATA = 8,
  parameter int ADD  = 7,
  parameter int WORD = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NDEV-1:0]          dev_rqst,
  input  logic [NDEV*(WORD+1)-1:0] dev_num_words,
  input  logic [NDEV*ADD-1:0]      dev_start_address,
  input  logic [NDEV-1:0]          dev_rd_wr,
  input  logic [NDEV-1:0]          dev_ack_in,
  input  logic [NDEV*DATA-1:0]     dev_data_in,
  output logic [NDEV-1:0]          dev_dma_ack,
  output logic [NDEV-1:0]          dev_end_flag,
  output logic [DATA-1:0]          dev_data_out,
  output logic                     dma_rqst,
  output logic [WORD:0]            dma_num_words,
  output logic [ADD-1:0]           dma_start_address,
  output logic                     dma_rd_wr,
  output logic                     dma_dev_ack,
  output logic [DATA-1:0]          dma_dev_out,
  input  logic                     dma_ack,
  input  logic                     dma_end_flag,
  input  logic [DATA-1:0]          dma_dev_in,
  output logic [NDEV-1:0]          grant,
  output logic                     busy
);
  localparam int IW = $clog2(NDEV);
  localparam int NW = WORD + 1;
  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;
  state_t state_q, state_d;
  logic [NDEV-1:0] grant_q, grant_d;
  logic [IW-1:0] w_q, w_d, win;
  logic [NW-1:0] nw_q, nw_d;
  logic [ADD-1:0] sa_q, sa_d;
  logic rw_q, rw_d, act;
`ifdef DMA_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d, j;
`endif
  // Scanning from the far end down means the last hit is the first candidate.
  always_comb begin
    win = '0;
`ifdef DMA_ARB_RR_EN
    j = '0;
`endif
    for (int k = NDEV - 1; k >= 0; k--) begin
`ifdef DMA_ARB_RR_EN
      j = IW'((int'(ptr_q) + 1 + k) % NDEV);
      if (dev_rqst[j]) win = j;
`else
      if (dev_rqst[IW'(k)]) win = IW'(k);
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    w_d = w_q;
    nw_d = nw_q;
    sa_d = sa_q;
    rw_d = rw_q;
`ifdef DMA_ARB_RR_EN
    ptr_d = ptr_q;
`endif
    case (state_q)
      IDLE: if (|dev_rqst) begin
        state_d = REQ;
        grant_d = NDEV'(1) << win;
        w_d = win;
        nw_d = dev_num_words[win*NW +: NW];
        sa_d = dev_start_address[win*ADD +: ADD];
        rw_d = dev_rd_wr[win];
`ifdef DMA_ARB_RR_EN
        ptr_d = win;
`endif
      end
      REQ: if (dma_ack) state_d = XFER;
        else if (!dev_rqst[w_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      XFER: if (dma_end_flag && !dma_ack) state_d = RELEASE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      w_q <= '0;
      nw_q <= '0;
      sa_q <= '0;
      rw_q <= 1'b0;
`ifdef DMA_ARB_RR_EN
      ptr_q <= IW'(NDEV - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      w_q <= w_d;
      nw_q <= nw_d;
      sa_q <= sa_d;
      rw_q <= rw_d;
`ifdef DMA_ARB_RR_EN
      ptr_q <= ptr_d;
`endif
    end
  end
  assign act = state_q != IDLE;
  assign busy = act;
  assign grant = grant_q;
  assign dma_rqst = state_q == REQ;
  assign dma_num_words = nw_q;
  assign dma_start_address = sa_q;
  assign dma_rd_wr = rw_q;
  assign dev_data_out = dma_dev_in;
  assign dev_dma_ack = act ? grant_q & {NDEV{dma_ack}} : '0;
  // RELEASE holds the end flag one extra cycle for the device's post-data states.
  assign dev_end_flag = act ? grant_q & {NDEV{dma_end_flag | (state_q == RELEASE)}} : '0;
  assign dma_dev_ack = act & dev_ack_in[w_q];
  assign dma_dev_out = act ? dev_data_in[w_q*DATA +: DATA] : '0;
endmodule
